jpeg_byte_unstuff: RTL and testbench

- Stage directly upstream of the DecHuff page. Its filebyte output stream feeds that page's filebyte input.
- Consumes the raw JPEG entropy-coded byte stream. Removes 0x00 stuffing bytes that follow 0xFF and discards 0xFF fill bytes.
- Diverts marker codes (RSTn, EOI, others) onto a separate marker stream, so DecHuff sees only clean scan data.
- Terminates the scan stream with an end-of-stream token at EOI.

---
 rtl/jpeg_byte_unstuff_if.sv | 18 +
 rtl/jpeg_byte_unstuff.sv | 161 ++++++++++++++++
 tb/tb_jpeg_byte_unstuff.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_byte_unstuff_if.sv
// rtl/jpeg_byte_unstuff_if.sv - token stream bundle (data, end-of-stream, valid, back-pressure)
//
// One instance per stream. The producer drives d/e/v and the consumer drives b;
// a token transfers on a clock edge where v is high and b is low.
//   d : 8-bit byte carried by the token
//   e : end-of-stream token flag, qualified by v
//   v : token valid
//   b : back-pressure from the consumer

interface jpeg_byte_unstuff_if;
  logic [7:0] d;
  logic       e;
  logic       v;
  logic       b;

  modport master (output d, output e, output v, input b);
  modport slave  (input d, input e, input v, output b);
endinterface

// File: rtl/jpeg_byte_unstuff.sv
// rtl/jpeg_byte_unstuff.sv - JPEG entropy-coded byte unstuffer and marker splitter
//
// Removes 0x00 stuffing after 0xFF, drops 0xFF fill bytes, sends marker codes
// to a separate stream and closes the scan stream with an end-of-stream token at EOI.
//   clock    : single clock, posedge
//   reset    : synchronous, active-high
//   rawbyte  : slave stream, raw file bytes in
//   filebyte : master stream, unstuffed scan bytes out
//   marker   : master stream, marker codes (second byte of FFxx) out
//   nbytes   : data bytes emitted on filebyte since the current image started
//   err      : sticky protocol error (image ended without EOI)

module jpeg_byte_unstuff #(
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  jpeg_byte_unstuff_if.slave    rawbyte,
  jpeg_byte_unstuff_if.master   filebyte,
  jpeg_byte_unstuff_if.master   marker,
  output logic [CNT_W-1:0]      nbytes,
  output logic                  err
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SAWFF   = 2'd1,
    EOI_EOS = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     state;

  logic [7:0] f_d;
  logic       f_e;
  logic       f_v;
  logic [7:0] m_d;
  logic       m_e;
  logic       m_v;

  logic       ready_f;
  logic       ready_m;
  logic       both_ready;
  logic       accept;

  assign filebyte.d = f_d;
  assign filebyte.e = f_e;
  assign filebyte.v = f_v;
  assign marker.d   = m_d;
  assign marker.e   = m_e;
  assign marker.v   = m_v;

  assign ready_f    = !f_v || !filebyte.b;
  assign ready_m    = !m_v || !marker.b;
  assign both_ready = ready_f && ready_m;

  // Both output registers must be free before any input is taken, so a stall on
  // either stream holds the whole block. EOI_EOS owns the outputs for one
  // token slot, so input is blocked there as well.
  assign rawbyte.b  = !both_ready || (state == EOI_EOS);
  assign accept     = rawbyte.v && !rawbyte.b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= NORMAL;
      f_d    <= 8'h00;
      f_e    <= 1'b0;
      f_v    <= 1'b0;
      m_d    <= 8'h00;
      m_e    <= 1'b0;
      m_v    <= 1'b0;
      nbytes <= '0;
      err    <= 1'b0;
    end else begin
      // Drop valid on transfer; any reload below overrides this.
      if (f_v && !filebyte.b) begin
        f_v <= 1'b0;
      end
      if (m_v && !marker.b) begin
        m_v <= 1'b0;
      end

      if (state == EOI_EOS) begin
        if (both_ready) begin
          f_v   <= 1'b1;
          f_e   <= 1'b1;
          f_d   <= 8'h00;
          m_v   <= 1'b1;
          m_e   <= 1'b1;
          m_d   <= 8'h00;
          state <= DONE;
        end
      end else if (accept) begin
        case (state)
          NORMAL: begin
            if (rawbyte.e) begin
              // Image ended without EOI: still close both streams.
              f_v   <= 1'b1;
              f_e   <= 1'b1;
              f_d   <= 8'h00;
              m_v   <= 1'b1;
              m_e   <= 1'b1;
              m_d   <= 8'h00;
              err   <= 1'b1;
              state <= DONE;
            end else if (rawbyte.d == 8'hFF) begin
              state <= SAWFF;
            end else begin
              f_v    <= 1'b1;
              f_e    <= 1'b0;
              f_d    <= rawbyte.d;
              nbytes <= nbytes + CNT_W'(1);
            end
          end

          SAWFF: begin
            if (rawbyte.e) begin
              // Pending 0xFF is dropped; the scan is closed anyway.
              f_v   <= 1'b1;
              f_e   <= 1'b1;
              f_d   <= 8'h00;
              m_v   <= 1'b1;
              m_e   <= 1'b1;
              m_d   <= 8'h00;
              err   <= 1'b1;
              state <= DONE;
            end else if (rawbyte.d == 8'h00) begin
              // Stuffed 0xFF data byte.
              f_v    <= 1'b1;
              f_e    <= 1'b0;
              f_d    <= 8'hFF;
              nbytes <= nbytes + CNT_W'(1);
              state  <= NORMAL;
            end else if (rawbyte.d == 8'hFF) begin
              // Fill byte: keep waiting for the marker code.
              state <= SAWFF;
            end else begin
              m_v   <= 1'b1;
              m_e   <= 1'b0;
              m_d   <= rawbyte.d;
              state <= (rawbyte.d == 8'hD9) ? EOI_EOS : NORMAL;
            end
          end

          DONE: begin
            // Trailing padding is discarded; the end token re-arms for the next image.
            if (rawbyte.e) begin
              nbytes <= '0;
              state  <= NORMAL;
            end
          end

          default: begin
            state <= NORMAL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jpeg_byte_unstuff.sv
// tb/tb_jpeg_byte_unstuff.sv - self-checking bench for jpeg_byte_unstuff

module tb_jpeg_byte_unstuff;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] nbytes;
  logic        err;

  always #5 clock = ~clock;

  jpeg_byte_unstuff_if raw_if ();
  jpeg_byte_unstuff_if f_if ();
  jpeg_byte_unstuff_if m_if ();

  jpeg_byte_unstuff #(.CNT_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .rawbyte  (raw_if),
    .filebyte (f_if),
    .marker   (m_if),
    .nbytes   (nbytes),
    .err      (err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rnd_bp = 1'b0;

  // Observed traffic: {e, d} plus the cycle it was seen.
  logic [8:0] got_f[$];
  logic [8:0] got_m[$];
  int         cyc_f[$];
  int         cyc_m[$];
  int         cyc_acc[$];

  // Reference model state and expected traffic.
  logic [8:0]  exp_f[$];
  logic [8:0]  exp_m[$];
  bit          m_pend;
  bit          m_done;
  logic [15:0] m_cnt;
  bit          m_err;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (raw_if.v && !raw_if.b) cyc_acc.push_back(cyc);
      if (f_if.v && !f_if.b) begin
        got_f.push_back({f_if.e, f_if.d});
        cyc_f.push_back(cyc);
      end
      if (m_if.v && !m_if.b) begin
        got_m.push_back({m_if.e, m_if.d});
        cyc_m.push_back(cyc);
      end
    end
  end

  function automatic void model_reset();
    m_pend = 1'b0;
    m_done = 1'b0;
    m_cnt  = 16'd0;
    m_err  = 1'b0;
  endfunction

  // Token-level rules of JPEG unstuffing, applied to one accepted input token.
  function automatic void model_push(input logic e, input logic [7:0] d);
    if (m_done) begin
      if (e) begin
        m_done = 1'b0;
        m_cnt  = 16'd0;
      end
    end else if (e) begin
      exp_f.push_back(9'h100);
      exp_m.push_back(9'h100);
      m_err  = 1'b1;
      m_pend = 1'b0;
      m_done = 1'b1;
    end else if (m_pend) begin
      if (d == 8'h00) begin
        exp_f.push_back({1'b0, 8'hFF});
        m_cnt  = m_cnt + 16'd1;
        m_pend = 1'b0;
      end else if (d != 8'hFF) begin
        exp_m.push_back({1'b0, d});
        m_pend = 1'b0;
        if (d == 8'hD9) begin
          exp_f.push_back(9'h100);
          exp_m.push_back(9'h100);
          m_done = 1'b1;
        end
      end
    end else if (d == 8'hFF) begin
      m_pend = 1'b1;
    end else begin
      exp_f.push_back({1'b0, d});
      m_cnt = m_cnt + 16'd1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic randomize_bp();
    f_if.b = ($urandom % 3) == 0;
    m_if.b = ($urandom % 4) == 0;
  endtask

  task automatic send_tok(input logic e, input logic [7:0] d);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    raw_if.v = 1'b1;
    raw_if.e = e;
    raw_if.d = e ? 8'h00 : d;
    do begin
      @(negedge clock);
      acc = !raw_if.b;
      @(posedge clock);
      #1;
      if (rnd_bp) randomize_bp();
      n++;
    end while (!acc && n < 300);
    chk("accept_timeout", {31'd0, acc}, 32'd1);
    if (acc) model_push(e, d);
  endtask

  task automatic idle(input int n);
    raw_if.v = 1'b0;
    raw_if.e = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
      if (rnd_bp) randomize_bp();
    end
  endtask

  task automatic drain();
    rnd_bp = 1'b0;
    f_if.b = 1'b0;
    m_if.b = 1'b0;
    idle(10);
  endtask

  task automatic clear_logs();
    got_f.delete();
    got_m.delete();
    cyc_f.delete();
    cyc_m.delete();
    cyc_acc.delete();
    exp_f.delete();
    exp_m.delete();
  endtask

  task automatic check_streams(input string tag);
    int n;
    chk({tag, " file_count"}, got_f.size(), exp_f.size());
    n = (got_f.size() < exp_f.size()) ? got_f.size() : exp_f.size();
    for (int i = 0; i < n; i++) begin
      if (exp_f[i][8]) chk({tag, " file_eos"}, {31'd0, got_f[i][8]}, 32'd1);
      else             chk({tag, " file_tok"}, {23'd0, got_f[i]}, {23'd0, exp_f[i]});
    end
    chk({tag, " marker_count"}, got_m.size(), exp_m.size());
    n = (got_m.size() < exp_m.size()) ? got_m.size() : exp_m.size();
    for (int i = 0; i < n; i++) begin
      if (exp_m[i][8]) chk({tag, " marker_eos"}, {31'd0, got_m[i][8]}, 32'd1);
      else             chk({tag, " marker_tok"}, {23'd0, got_m[i]}, {23'd0, exp_m[i]});
    end
    chk({tag, " nbytes"}, {16'd0, nbytes}, {16'd0, m_cnt});
    chk({tag, " err"}, {31'd0, err}, {31'd0, m_err});
    clear_logs();
  endtask

  task automatic do_reset(input string tag);
    raw_if.v = 1'b0;
    raw_if.e = 1'b0;
    raw_if.d = 8'h00;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, " rst f_v"}, {31'd0, f_if.v}, 32'd0);
    chk({tag, " rst f_e"}, {31'd0, f_if.e}, 32'd0);
    chk({tag, " rst f_d"}, {24'd0, f_if.d}, 32'd0);
    chk({tag, " rst m_v"}, {31'd0, m_if.v}, 32'd0);
    chk({tag, " rst m_e"}, {31'd0, m_if.e}, 32'd0);
    chk({tag, " rst m_d"}, {24'd0, m_if.d}, 32'd0);
    chk({tag, " rst nbytes"}, {16'd0, nbytes}, 32'd0);
    chk({tag, " rst err"}, {31'd0, err}, 32'd0);
    reset = 1'b0;
    model_reset();
    clear_logs();
  endtask

  initial begin
    logic [7:0] t1[5];
    logic [7:0] t2[6];
    int fi;
    int mi;
    int r;

    raw_if.v = 1'b0;
    raw_if.e = 1'b0;
    raw_if.d = 8'h00;
    f_if.b   = 1'b0;
    m_if.b   = 1'b0;
    model_reset();

    // Plain data with one stuffed FF, back to back.
    do_reset("t1");
    t1 = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56};
    foreach (t1[i]) send_tok(1'b0, t1[i]);
    idle(4);
    chk("t1 accept_span", (cyc_acc.size() == 5) ? cyc_acc[4] - cyc_acc[0] : -1, 32'd4);
    chk("t1 first_latency", (cyc_f.size() == 4 && cyc_acc.size() == 5) ? cyc_f[0] - cyc_acc[0] : -1, 32'd1);
    chk("t1 last_latency", (cyc_f.size() == 4 && cyc_acc.size() == 5) ? cyc_f[3] - cyc_acc[4] : -1, 32'd1);
    check_streams("t1");

    // Fill bytes before an RST marker.
    do_reset("t2");
    t2 = '{8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'hD3, 8'hCD};
    foreach (t2[i]) send_tok(1'b0, t2[i]);
    idle(4);
    check_streams("t2");

    // EOI, trailing padding, then end token re-arming the next image.
    do_reset("t3");
    send_tok(1'b0, 8'h01);
    send_tok(1'b0, 8'hFF);
    send_tok(1'b0, 8'hD9);
    idle(3);
    chk("t3 nbytes_after_eoi", {16'd0, nbytes}, 32'd1);
    send_tok(1'b0, 8'h77);
    send_tok(1'b0, 8'h88);
    send_tok(1'b1, 8'h00);
    idle(4);
    fi = -1;
    mi = -1;
    foreach (got_f[i]) if (got_f[i][8] && fi < 0) fi = i;
    foreach (got_m[i]) if (got_m[i][8] && mi < 0) mi = i;
    chk("t3 eos_same_cycle", (fi >= 0) ? cyc_f[fi] : -1, (mi >= 0) ? cyc_m[mi] : -2);
    check_streams("t3");
    send_tok(1'b0, 8'h42);
    idle(3);
    check_streams("t3 next_image");

    // filebyte held off for 5 cycles while holding a token.
    do_reset("t4");
    f_if.b = 1'b1;
    send_tok(1'b0, 8'h10);
    raw_if.d = 8'h11;
    raw_if.e = 1'b0;
    raw_if.v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t4 stall rawbyte_b", {31'd0, raw_if.b}, 32'd1);
      chk("t4 stall f_v", {31'd0, f_if.v}, 32'd1);
      chk("t4 stall f_d", {24'd0, f_if.d}, 32'h10);
    end
    @(posedge clock);
    #1;
    chk("t4 no_accept_during_stall", cyc_acc.size(), 32'd1);
    f_if.b = 1'b0;
    send_tok(1'b0, 8'h11);
    send_tok(1'b0, 8'h12);
    idle(4);
    check_streams("t4");

    // Image ends with a dangling FF and no EOI; err is sticky.
    do_reset("t5");
    send_tok(1'b0, 8'h55);
    send_tok(1'b0, 8'hFF);
    send_tok(1'b1, 8'h00);
    idle(4);
    check_streams("t5");
    send_tok(1'b1, 8'h00);
    send_tok(1'b0, 8'h66);
    send_tok(1'b0, 8'hFF);
    send_tok(1'b0, 8'hD9);
    send_tok(1'b1, 8'h00);
    idle(4);
    check_streams("t5 next_image");
    chk("t5 err_sticky", {31'd0, err}, 32'd1);

    // Reset while an FF is pending.
    do_reset("t6");
    send_tok(1'b0, 8'hFF);
    idle(1);
    do_reset("t6 mid");
    send_tok(1'b0, 8'h00);
    send_tok(1'b0, 8'h41);
    idle(4);
    check_streams("t6");

    // Random traffic with random back-pressure on both outputs.
    for (int round = 0; round < 3; round++) begin
      do_reset("rnd");
      rnd_bp = 1'b1;
      for (int i = 0; i < 400; i++) begin
        r = $urandom % 64;
        if (r < 14)       send_tok(1'b0, 8'hFF);
        else if (r < 20)  send_tok(1'b0, 8'h00);
        else if (r < 22)  send_tok(1'b0, 8'hD9);
        else if (r < 26)  send_tok(1'b0, 8'hD0 + 8'($urandom % 8));
        else if (r < 28)  send_tok(1'b1, 8'h00);
        else              send_tok(1'b0, 8'($urandom));
        if (($urandom % 8) == 0) idle(1 + $urandom % 3);
      end
      drain();
      check_streams("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
